stf_seq_player: RTL and testbench

- Parametrised successor to the fixed L-STF lookup table: a run-time-writable I/Q period table plus a playback engine.
- On `start`, it streams the stored period a programmable number of times over a valid/ready sample interface, flagging the final sample.
- Sits in openofdm_tx ahead of the preamble/data mux. It generalises period length, sample width and repetition count, and adds flow control.

---
 rtl/stf_seq_player.sv | 190 +++++++++++++++++++
 tb/tb_stf_seq_player.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stf_seq_player.sv
// stf_seq_player: run-time writable I/Q period table plus a valid/ready playback
// engine that replays the stored period num_rep times and flags the final sample.
// Optional edge windowing is enabled with `define STF_SEQ_PLAYER_WINDOW_EN: the
// first sample is halved and a halved copy of entry 0 is appended as a tail sample.
module stf_seq_player #(
    parameter int unsigned IQ_WIDTH  = 16,
    parameter int unsigned PERIOD    = 16,
    parameter int unsigned REP_WIDTH = 4,
    parameter int unsigned AW        = $clog2(PERIOD)
) (
    input  logic                  clk,
    input  logic                  phy_tx_arest,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [2*IQ_WIDTH-1:0] cfg_wdata,
    input  logic                  start,
    input  logic [REP_WIDTH-1:0]  num_rep,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [2*IQ_WIDTH-1:0] m_tdata,
    output logic                  m_tlast
);

    localparam int unsigned DW = 2 * IQ_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1
`ifdef STF_SEQ_PLAYER_WINDOW_EN
        , S_TAIL = 2'd2
`endif
    } state_t;

    state_t                state, state_nxt;
    logic [DW-1:0]         tbl [PERIOD];
    logic [AW-1:0]         addr, addr_nxt, addr_inc;
    logic [REP_WIDTH-1:0]  rep, rep_nxt, rep_inc;
    logic [REP_WIDTH-1:0]  nrep, nrep_nxt, nrep_m1;
    logic [DW-1:0]         data_nxt;
    logic                  valid_nxt, last_nxt, busy_nxt, done_nxt;
    logic                  xfer, accept, at_end, wr_ok;

`ifdef STF_SEQ_PLAYER_WINDOW_EN
    // Arithmetic halving of I and Q independently
    function automatic logic [DW-1:0] halve(input logic [DW-1:0] s);
        return {s[DW-1], s[DW-1:IQ_WIDTH+1], s[IQ_WIDTH-1], s[IQ_WIDTH-1:1]};
    endfunction
`endif

    assign xfer     = m_tvalid & m_tready;
    assign accept   = start & ~abort & (num_rep != '0);
    assign nrep_m1  = nrep - REP_WIDTH'(1);
    assign at_end   = (addr == LAST_ADDR) && (rep == nrep_m1);
    assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + AW'(1);
    assign rep_inc  = (addr == LAST_ADDR) ? rep + REP_WIDTH'(1) : rep;
    assign wr_ok    = cfg_we & ~busy & ({1'b0, cfg_addr} < (AW+1)'(PERIOD));

    // State register
    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Next-state logic; abort takes priority over any handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_PLAY;
            S_PLAY: begin
                if (abort) state_nxt = S_IDLE;
`ifdef STF_SEQ_PLAYER_WINDOW_EN
                else if (xfer && at_end) state_nxt = S_TAIL;
`else
                else if (xfer && at_end) state_nxt = S_IDLE;
`endif
            end
`ifdef STF_SEQ_PLAYER_WINDOW_EN
            S_TAIL: if (abort || xfer) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of sequencing registers and registered outputs
    always_comb begin
        addr_nxt  = addr;
        rep_nxt   = rep;
        nrep_nxt  = nrep;
        data_nxt  = m_tdata;
        valid_nxt = m_tvalid;
        last_nxt  = m_tlast;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nrep_nxt  = num_rep;
                    addr_nxt  = '0;
                    rep_nxt   = '0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    last_nxt  = 1'b0;
`ifdef STF_SEQ_PLAYER_WINDOW_EN
                    data_nxt  = halve(tbl[0]);
`else
                    data_nxt  = tbl[0];
`endif
                end
            end
            S_PLAY: begin
                if (abort) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    last_nxt  = 1'b0;
                end else if (xfer && at_end) begin
`ifdef STF_SEQ_PLAYER_WINDOW_EN
                    data_nxt  = halve(tbl[0]);
                    last_nxt  = 1'b1;
`else
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    last_nxt  = 1'b0;
                    done_nxt  = 1'b1;
`endif
                end else if (xfer) begin
                    addr_nxt = addr_inc;
                    rep_nxt  = rep_inc;
                    data_nxt = tbl[addr_inc];
`ifdef STF_SEQ_PLAYER_WINDOW_EN
                    last_nxt = 1'b0;
`else
                    last_nxt = (addr_inc == LAST_ADDR) && (rep_inc == nrep_m1);
`endif
                end
            end
`ifdef STF_SEQ_PLAYER_WINDOW_EN
            S_TAIL: begin
                if (abort || xfer) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    last_nxt  = 1'b0;
                    done_nxt  = ~abort;
                end
            end
`endif
            default: begin
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // Sequencing and output registers
    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            addr     <= '0;
            rep      <= '0;
            nrep     <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            addr     <= addr_nxt;
            rep      <= rep_nxt;
            nrep     <= nrep_nxt;
            m_tdata  <= data_nxt;
            m_tvalid <= valid_nxt;
            m_tlast  <= last_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Period table, writable only while idle
    always_ff @(posedge clk or posedge phy_tx_arest) begin
        if (phy_tx_arest) begin
            for (int unsigned i = 0; i < PERIOD; i++) tbl[i] <= '0;
        end else if (wr_ok) begin
            tbl[cfg_addr] <= cfg_wdata;
        end
    end

endmodule

// File: tb/tb_stf_seq_player.sv
// Testbench for stf_seq_player: directed steps with random ready/noise, checked
// against an expected-sample queue built from a copy of the table contents.
module tb_stf_seq_player;

    localparam int unsigned IQW = 16;
    localparam int unsigned P   = 16;
    localparam int unsigned RW  = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 2 * IQW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          start;
    logic [RW-1:0] num_rep;
    logic          abort;
    logic          busy, done, m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] model [P];
    logic [DW-1:0] expq [$];

    always #5 clk = ~clk;

    stf_seq_player #(.IQ_WIDTH(IQW), .PERIOD(P), .REP_WIDTH(RW)) dut (
        .clk(clk), .phy_tx_arest(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .num_rep(num_rep), .abort(abort),
        .busy(busy), .done(done), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] half(input logic [DW-1:0] s);
        logic signed [IQW-1:0] i, q;
        i = s[DW-1:IQW];
        q = s[IQW-1:0];
        i = i >>> 1;
        q = q >>> 1;
        return {i, q};
    endfunction

    // Expected burst: the period repeated nrep times, with window edits if enabled
    task automatic build_exp(input int nrep);
        expq.delete();
        for (int r = 0; r < nrep; r++)
            for (int a = 0; a < int'(P); a++) expq.push_back(model[a]);
`ifdef STF_SEQ_PLAYER_WINDOW_EN
        expq[0] = half(model[0]);
        expq.push_back(half(model[0]));
`endif
    endtask

    task automatic write_entry(input int a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        model[a] = d;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk1({tag, "_valid"}, m_tvalid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_last"}, m_tlast, 1'b0);
    endtask

    // Run one burst; stop_at >= 0 aborts (or resets) after that many transfers
    task automatic play(input int nrep, input bit rnd, input int stop_at, input bit use_rst,
                        input bit noise, input bit chain, input bit do_start);
        int idx = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        build_exp(nrep);
        if (do_start) begin
            start = 1'b1; num_rep = RW'(nrep);
            @(negedge clk);
            start = 1'b0;
        end
        while (idx < expq.size()) begin
            if (cyc++ > 4000) begin
                tests++; fails++;
                $error("FAIL timeout transfers=%0d expected=%0d", idx, expq.size());
                break;
            end
            if (idx == stop_at) begin
                if (use_rst) begin
                    rst = 1'b1;
                    #1;
                    chk_idle_outputs("rst_mid");
                    chk1("rst_mid_done", done, 1'b0);
                    chkd("rst_mid_data", m_tdata, '0);
                    @(negedge clk);
                    rst = 1'b0;
                    for (int a = 0; a < int'(P); a++) model[a] = '0;
                end else begin
                    abort = 1'b1; m_tready = 1'b0; start = 1'b0; cfg_we = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    chk_idle_outputs("abort");
                    chk1("abort_done", done, 1'b0);
                    @(negedge clk);
                    chk1("abort_done2", done, 1'b0);
                    chk1("abort_valid2", m_tvalid, 1'b0);
                end
                return;
            end
            chk1("valid", m_tvalid, 1'b1);
            chk1("busy", busy, 1'b1);
            if (stall) begin
                chkd("stall_data", m_tdata, pd);
                chk1("stall_last", m_tlast, pl);
            end
            chkd("data", m_tdata, expq[idx]);
            chk1("last", m_tlast, idx == expq.size() - 1);
            m_tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            num_rep   = RW'($urandom);
            cfg_we    = noise;
            cfg_addr  = AW'($urandom);
            cfg_wdata = DW'($urandom);
            stall = !m_tready;
            pd = m_tdata;
            pl = m_tlast;
            if (m_tready) idx++;
            @(negedge clk);
        end
        m_tready = 1'b0; start = 1'b0; cfg_we = 1'b0;
        chk_idle_outputs("end");
        chk1("end_done", done, 1'b1);
        if (chain) begin
            start = 1'b1; num_rep = RW'(nrep);
        end
        @(negedge clk);
        start = 1'b0;
        chk1("done_pulse", done, 1'b0);
        chk1("post_valid", m_tvalid, chain);
    endtask

    initial begin
        logic [DW-1:0] stf [P];
        stf[0]  = 32'hfd0efd0e; stf[1]  = 32'h0000fd0e; stf[2]  = 32'h0000fbd6; stf[3]  = 32'h042a0000;
        stf[4]  = 32'h02f20000; stf[5]  = 32'h042a0000; stf[6]  = 32'h042a0000; stf[7]  = 32'hfbd60000;
        stf[8]  = 32'h02f202f2; stf[9]  = 32'h0000fbd6; stf[10] = 32'hfd0e0000; stf[11] = 32'h0000042a;
        stf[12] = 32'h000002f2; stf[13] = 32'hfe68fc27; stf[14] = 32'hfd0efe68; stf[15] = 32'hfc27fe68;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; num_rep = '0; abort = 1'b0; m_tready = 1'b0;
        for (int a = 0; a < int'(P); a++) model[a] = '0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk1("reset_done", done, 1'b0);
        chkd("reset_data", m_tdata, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int a = 0; a < int'(P); a++) write_entry(a, stf[a]);

        // Full-throughput burst of 10 periods
        play(10, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Random back-pressure, with writes and starts injected while busy
        play(10, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b1);
        // Table must still hold the original period
        play(10, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);

        // num_rep = 0 is ignored
        start = 1'b1; num_rep = '0;
        @(negedge clk);
        start = 1'b0;
        chk_idle_outputs("rep0");
        @(negedge clk);
        chk1("rep0_done", done, 1'b0);
        chk1("rep0_valid2", m_tvalid, 1'b0);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1; num_rep = 4'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_idle_outputs("abort_start");
        @(negedge clk);
        chk1("abort_start_valid2", m_tvalid, 1'b0);

        // Abort after 37 transfers, then replay from entry 0
        play(10, 1'b1, 37, 1'b0, 1'b0, 1'b0, 1'b1);
        play(2, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);

        // start in the done cycle is accepted
        play(1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
        play(1, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random table contents and repetition counts
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < int'(P); a++) write_entry(a, DW'($urandom));
            play($urandom_range(1, 15), 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Reset mid-burst at sample 50, then replay of a cleared table
        for (int a = 0; a < int'(P); a++) write_entry(a, stf[a]);
        play(10, 1'b1, 50, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        play(3, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
